char_classifier: RTL
====================

Name: char_classifier

Overview:
- Upstream stage of the string-recognizer FSM.
- Accepts raw bytes from the UART receiver and buffers them in a small FIFO.
- Pops bytes one at a time and drives the recognizer's one-hot-ish character-class flags with a single-cycle valid strobe.
- Enforces a minimum idle gap between strobes and supports a stall input, so the FSM's STOP/ERROR handling is never overrun.

Parameters:
- DEPTH, 8, FIFO depth in bytes (power of two, ≥2).
- GAP, 1, minimum idle cycles between consecutive valid pulses (0 = back-to-back allowed).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid this cycle.
- stall  in  1  when high, no byte is popped.
- clr_overflow  in  1  synchronous clear of overflow.
- valid  out  1  one-cycle strobe: flags/char_out describe a new character.
- char_out  out  8  byte currently described.
- start_stop, small_letter, capital_letter, number, hex_digit, punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol, whitespace, vowel, consonant, other  out  1 each  class flags for char_out.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_count=0, valid=0, char_out=0x00, all flags 0, overflow=0, gap counter=0. Reset mid-stream discards buffered bytes and any pending strobe immediately.
- Push: on each clk edge with rx_valid=1, rx_data is written if the FIFO is not full.
- Full FIFO:
  - Push with a simultaneous pop in the same edge is accepted; count is unchanged.
  - Push without a pop drops the byte and sets overflow.
- Overflow clearing: overflow clears only on rst, or on clr_overflow=1 at an edge. If a drop and clr_overflow occur on the same edge, overflow stays set.
- Pop condition, evaluated at each edge: FIFO non-empty, stall=0, and gap_cnt=0.
- On pop:
  - The head byte is registered into char_out and its flags are computed from that byte and registered.
  - valid=1 for exactly the following cycle.
  - gap_cnt is loaded with GAP.
- On non-pop edges: valid=0 and gap_cnt decrements if non-zero.
- Hold between strobes: char_out and flags hold their last value between strobes.
- Latency: a byte sampled into an empty FIFO at edge t (gap_cnt=0, stall=0) is popped at edge t+1. valid is high in the cycle after edge t+1.
- Ordering and wrap-around: strict FIFO order. Read and write pointers wrap modulo DEPTH.
- Classification (combinational on the head byte, registered at pop):
  - start_stop: 0x00.
  - small_letter: a–z.
  - capital_letter: A–Z.
  - number: 0–9.
  - hex_digit: 0–9, A–F, a–f.
  - punctuation_basic: . , : ; ! ? ' "
  - punctuation_finance: # $ % & @
  - parentheses: ( ) [ ]
  - curly_braces: { }
  - math_symbol: + - * / \ = < >
  - whitespace: 0x20, 0x09, 0x0A, 0x0D.
  - vowel: aeiouAEIOU.
  - consonant: any letter that is not a vowel.
  - other: none of start_stop, letter, number, punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol, whitespace. Examples: '_', '~', 0x80–0xFF, control codes other than the whitespace codes.
- Flag overlaps: multiple flags may be high together (e.g. 'a' → small_letter, hex_digit, vowel). other is never high together with any other flag.
- Stall: stall=1 blocks pops only. Pushes continue, and gap_cnt still decrements.

Test Plan:
- Push "3F\0" with GAP=1, no stall → three valid pulses spaced 2 cycles apart: '3' (number, hex_digit); 'F' (capital_letter, hex_digit, consonant); 0x00 (start_stop only). First pulse occurs 2 edges after the first push.
- Single bytes 'e', 'z', '@', '{', '\t', '~' → flags respectively: small_letter+hex_digit+vowel; small_letter+consonant; punctuation_finance; curly_braces; whitespace; other. No other flags high.
- stall=1 while pushing 8 bytes (DEPTH=8) → fifo_count=8, no valid. A 9th push sets overflow=1 and the byte is dropped. Release stall → exactly the first 8 bytes emerge in order.
- FIFO full, push and pop on the same edge → byte accepted, overflow stays 0, fifo_count stays 8. Pointers wrap correctly over 20 bytes streamed with GAP=0; output order matches input.
- GAP=0 with a continuous FIFO supply → valid high on consecutive cycles. GAP=3 → exactly 3 idle cycles between pulses.
- Assert rst asynchronously mid-stream (between edges) → valid, flags, char_out, fifo_count, and overflow go to 0 immediately. After release, no stale bytes are emitted.

Source files
------------

// File: rtl/char_classifier.sv
// Byte FIFO feeding the string recognizer: pops one byte at a time, classifies it,
// and emits a single-cycle valid strobe with a programmable minimum gap between strobes.
module char_classifier #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned GAP   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   input  logic                       stall,
   input  logic                       clr_overflow,
   output logic                       valid,
   output logic [7:0]                 char_out,
   output logic                       start_stop,
   output logic                       small_letter,
   output logic                       capital_letter,
   output logic                       number,
   output logic                       hex_digit,
   output logic                       punctuation_basic,
   output logic                       punctuation_finance,
   output logic                       parentheses,
   output logic                       curly_braces,
   output logic                       math_symbol,
   output logic                       whitespace,
   output logic                       vowel,
   output logic                       consonant,
   output logic                       other,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned GW = $clog2(GAP + 2);
   localparam int unsigned NF = 14;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [GW-1:0] gap_cnt;
   logic [NF-1:0] cls_q;

   logic          empty_c, full_c, pop_c, push_c, drop_c;
   logic [7:0]    head_c;
   logic [NF-1:0] cls_c;
   logic          ss_c, sm_c, cap_c, num_c, hex_c, pb_c, pf_c, par_c;
   logic          cur_c, math_c, ws_c, vow_c, con_c, oth_c;

   assign empty_c = (count == '0);
   assign full_c  = (count == CW'(DEPTH));
   assign pop_c   = !empty_c && !stall && (gap_cnt == '0);
   // A full FIFO still accepts a byte when the same edge frees a slot.
   assign push_c  = rx_valid && (!full_c || pop_c);
   assign drop_c  = rx_valid && full_c && !pop_c;
   assign head_c  = mem[rd_ptr];

   // Character classes of the head byte.
   always_comb begin
      ss_c   = (head_c == 8'h00);
      sm_c   = (head_c >= 8'h61) && (head_c <= 8'h7A);
      cap_c  = (head_c >= 8'h41) && (head_c <= 8'h5A);
      num_c  = (head_c >= 8'h30) && (head_c <= 8'h39);
      hex_c  = num_c || ((head_c >= 8'h41) && (head_c <= 8'h46))
                     || ((head_c >= 8'h61) && (head_c <= 8'h66));
      pb_c   = 1'b0;
      pf_c   = 1'b0;
      par_c  = 1'b0;
      cur_c  = 1'b0;
      math_c = 1'b0;
      ws_c   = 1'b0;
      vow_c  = 1'b0;
      case (head_c)
         8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h21, 8'h3F, 8'h27, 8'h22: pb_c   = 1'b1;
         8'h23, 8'h24, 8'h25, 8'h26, 8'h40:                      pf_c   = 1'b1;
         8'h28, 8'h29, 8'h5B, 8'h5D:                             par_c  = 1'b1;
         8'h7B, 8'h7D:                                           cur_c  = 1'b1;
         8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E: math_c = 1'b1;
         8'h20, 8'h09, 8'h0A, 8'h0D:                             ws_c   = 1'b1;
         8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
         8'h41, 8'h45, 8'h49, 8'h4F, 8'h55:                      vow_c  = 1'b1;
         default: ;
      endcase
      con_c  = (sm_c || cap_c) && !vow_c;
      oth_c  = !(ss_c || sm_c || cap_c || num_c || pb_c || pf_c || par_c
                 || cur_c || math_c || ws_c);
      cls_c  = {ss_c, sm_c, cap_c, num_c, hex_c, pb_c, pf_c, par_c,
                cur_c, math_c, ws_c, vow_c, con_c, oth_c};
   end

   // Storage array carries no reset; occupancy tracking makes stale entries invisible.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         gap_cnt  <= '0;
         valid    <= 1'b0;
         char_out <= 8'h00;
         cls_q    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         count    <= count + CW'(push_c) - CW'(pop_c);
         overflow <= drop_c || (overflow && !clr_overflow);
         valid    <= pop_c;
         if (pop_c) begin
            rd_ptr   <= rd_ptr + PW'(1);
            char_out <= head_c;
            cls_q    <= cls_c;
            gap_cnt  <= GW'(GAP);
         end else if (gap_cnt != '0) begin
            gap_cnt  <= gap_cnt - GW'(1);
         end
      end
   end

   assign fifo_count = count;
   assign {start_stop, small_letter, capital_letter, number, hex_digit,
           punctuation_basic, punctuation_finance, parentheses, curly_braces,
           math_symbol, whitespace, vowel, consonant, other} = cls_q;

endmodule
